scan_encoder: RTL and testbench



---
 rtl/scan_encoder_pkg.sv | 14 +
 rtl/scan_encoder_if.sv | 26 ++
 rtl/scan_encoder_prio_find.sv | 31 +++
 rtl/scan_encoder.sv | 82 ++++++++
 tb/tb_scan_encoder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/scan_encoder_pkg.sv
// Shared types and helpers for the sequential multi-hot to binary-index encoder.
package scan_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Width of a binary index that addresses n request bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_encoder_if.sv
// Input-vector and output-index handshakes of scan_encoder.
interface scan_encoder_if
  import scan_encoder_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;

  // master: request source plus index consumer; slave: the encoder
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/scan_encoder_prio_find.sv
// Combinational priority bit-find: binary index and one-hot of the winning set bit.
// Winner is the lowest set bit, or the highest when SCAN_ENC_MSB_FIRST_EN is defined.
module prio_find
  import scan_encoder_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // The scan order is chosen so the last hit seen is the winner.
  always_comb begin
    idx    = '0;
    onehot = '0;
`ifdef SCAN_ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
`else
    for (int i = N - 1; i >= 0; i--) begin
`endif
      if (vec[i]) begin
        idx       = W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_encoder.sv
// Sequential N-to-log2(N) encoder: emits the index of every set bit of an accepted
// vector, one per beat. Optional macro SCAN_ENC_MSB_FIRST_EN selects MSB-first order.
module scan_encoder
  import scan_encoder_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  scan_encoder_if.slave        bus,
  output logic                 zero_err,
  output logic                 busy
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [N-1:0] pending, pending_nxt;
  logic [N-1:0] win_oh;
  logic [W-1:0] win_idx;
  logic         zero_q, zero_nxt;
  logic         last, in_rdy, out_vld;

  prio_find #(.N(N), .W(W)) u_find (
    .vec   (pending),
    .idx   (win_idx),
    .onehot(win_oh)
  );

  // Exactly one bit left: non-zero and clearing the lowest bit leaves nothing.
  assign last = (pending != '0) && ((pending & (pending - ONE)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      zero_q  <= zero_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    zero_nxt    = 1'b0;
    in_rdy      = 1'b0;
    out_vld     = 1'b0;
    case (state)
      ST_IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_vec != '0) begin
            pending_nxt = bus.in_vec;
            state_nxt   = ST_SCAN;
          end else begin
            zero_nxt = 1'b1;
          end
        end
      end
      ST_SCAN: begin
        out_vld = 1'b1;
        if (bus.out_ready) begin
          pending_nxt = pending & ~win_oh;
          if (last) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_idx   = win_idx;
  assign bus.out_last  = last;
  assign zero_err      = zero_q;
  assign busy          = (state == ST_SCAN);

endmodule

// File: tb/tb_scan_encoder.sv
// Randomized self-checking bench for scan_encoder against a bit-order reference model.
module tb_scan_encoder;
  localparam int N = 4;
  localparam int W = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic zero_err, busy;
  int   total = 0;
  int   bad   = 0;

  scan_encoder_if #(.N(N), .W(W)) bus ();

  scan_encoder #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .zero_err(zero_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Accepts v, then drains beats; stall = leading cycles with out_ready low,
  // rnd = random out_ready afterwards. Garbage is offered on in_* during the scan.
  task automatic run_vector(input logic [N-1:0] v, input int stall, input bit rnd, input string tag);
    int exp[$];
    int cyc;
    logic [W+3:0] got, want;
    exp.delete();
`ifdef SCAN_ENC_MSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) if (v[i]) exp.push_back(i);
`else
    for (int i = 0; i < N; i++) if (v[i]) exp.push_back(i);
`endif
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_vec    = v;
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL %s accept_ready got=%b want=1", tag, bus.in_ready);
    end
    @(negedge clk);
    if (v == '0) begin
      bus.in_valid = 1'b0;
      total++;
      if ({zero_err, bus.out_valid, bus.in_ready, busy} !== 4'b1010) begin
        bad++; $display("FAIL %s zero_pulse got=%b want=1010", tag, {zero_err, bus.out_valid, bus.in_ready, busy});
      end
      @(negedge clk);
      total++;
      if ({zero_err, bus.out_valid, bus.in_ready} !== 3'b001) begin
        bad++; $display("FAIL %s zero_clear got=%b want=001", tag, {zero_err, bus.out_valid, bus.in_ready});
      end
      return;
    end
    cyc = 0;
    while (exp.size() > 0 && cyc < 64) begin
      bus.out_ready = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.in_valid  = !(bus.out_ready && exp.size() == 1);
      bus.in_vec    = N'($urandom);
      got  = {bus.out_valid, busy, bus.in_ready, bus.out_idx, bus.out_last};
      want = {1'b1, 1'b1, 1'b0, W'(exp[0]), exp.size() == 1};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL %s beat%0d {vld,busy,rdy,idx,last} got=%b want=%b", tag, cyc, got, want);
      end
      @(posedge clk);
      if (bus.out_ready) void'(exp.pop_front());
      @(negedge clk);
      cyc++;
    end
    total++;
    if (exp.size() != 0) begin
      bad++; $display("FAIL %s drain_timeout left=%0d want=0", tag, exp.size());
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    total++;
    if ({bus.out_valid, busy, bus.in_ready, zero_err} !== 4'b0010) begin
      bad++; $display("FAIL %s back_idle got=%b want=0010", tag, {bus.out_valid, busy, bus.in_ready, zero_err});
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, zero_err, busy} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000}) begin
      bad++; $display("FAIL reset_state got=%b", {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, zero_err, busy});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_vector(4'b1011, 0, 1'b0, "basic_1011");
  endtask

  task automatic test_stall();
    run_vector(4'b0110, 3, 1'b0, "stall_0110");
  endtask

  task automatic test_zero();
    run_vector(4'b0000, 0, 1'b0, "zero_vec");
    // Block must still work normally right after a zero vector.
    run_vector(4'b0100, 0, 1'b0, "after_zero");
  endtask

  task automatic test_boundary();
    run_vector(4'b1000, 0, 1'b0, "single_1000");
    run_vector(4'b0001, 1, 1'b0, "single_0001");
    run_vector(4'b1111, 0, 1'b0, "all_ones");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_vec = 4'b1111; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    #2;
    total++;
    if ({bus.out_valid, busy} !== 2'b11) begin
      bad++; $display("FAIL midrst_pre got=%b want=11", {bus.out_valid, busy});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, busy, bus.out_last, bus.out_idx, bus.in_ready, zero_err} !== {3'b000, {W{1'b0}}, 2'b10}) begin
      bad++; $display("FAIL midrst_async got=%b", {bus.out_valid, busy, bus.out_last, bus.out_idx, bus.in_ready, zero_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({bus.out_valid, busy, bus.in_ready} !== 3'b001) begin
        bad++; $display("FAIL midrst_after%0d got=%b want=001", i, {bus.out_valid, busy, bus.in_ready});
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_vector(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 2), 1'b1, $sformatf("rand%0d", k));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_boundary();
    test_reset_mid();
    test_random();
    test_basic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
